// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared encodings for the multi-cycle instruction sequencer
package seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam int CP_PC_WE       = 8;
  localparam int CP_IR_WE       = 7;
  localparam int CP_REG_WE      = 6;
  localparam int CP_MEM_RE      = 5;
  localparam int CP_MEM_WE      = 4;
  localparam int CP_ALU_SRC_IMM = 3;
  localparam int CP_WB_SEL_MEM  = 2;
  localparam int CP_PC_SRC_BR   = 1;
  localparam int CP_PC_SRC_JMP  = 0;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // 9..E are the unassigned holes in the opcode map
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// rtl/seq_ctrl_decode.sv - combinational control word and ALU opcode decode from state and latched op
module seq_ctrl_decode
  import seq_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic [8:0] control_pipe,
  output logic [1:0] alu_opcode
);

  always_comb begin
    control_pipe = '0;
    alu_opcode   = ALU_ADD;
    case (state)
      ST_FETCH: begin
        control_pipe[CP_MEM_RE] = 1'b1;
        if (mem_ready) begin
          control_pipe[CP_IR_WE] = 1'b1;
          control_pipe[CP_PC_WE] = 1'b1;
        end
      end
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: alu_opcode = op[1:0];
          OP_ADDI, OP_LW, OP_SW:         control_pipe[CP_ALU_SRC_IMM] = 1'b1;
          OP_BEQ: begin
            alu_opcode                 = ALU_SUB;
            control_pipe[CP_PC_WE]     = alu_zero;
            control_pipe[CP_PC_SRC_BR] = alu_zero;
          end
          OP_JMP: begin
            control_pipe[CP_PC_WE]      = 1'b1;
            control_pipe[CP_PC_SRC_JMP] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (op == OP_LW) control_pipe[CP_MEM_RE] = 1'b1;
        else if (op == OP_SW) control_pipe[CP_MEM_WE] = 1'b1;
      end
      ST_WB: begin
        control_pipe[CP_REG_WE]     = 1'b1;
        control_pipe[CP_WB_SEL_MEM] = (op == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic [8:0]       control_pipe,
  output logic [1:0]       alu_opcode,
  output logic [2:0]       state_o,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          state, state_next;
  logic [3:0]      op_q;
  logic [TO_W-1:0] to_cnt;
  logic            mem_wait, timeout, retire;

  assign mem_wait = (state == ST_FETCH) || (state == ST_MEM);
  assign timeout  = (MEM_TIMEOUT > 0) && mem_wait && !mem_ready && (to_cnt == TO_LAST);
  assign state_o  = state;
  assign halted   = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      ST_FETCH: begin
        if (mem_ready)    state_next = ST_DECODE;
        else if (timeout) state_next = ST_HALT;
      end
      ST_DECODE: begin
        if (opcode == OP_HLT) begin
          state_next = ST_HALT;
        end else if (is_illegal(opcode)) begin
          illegal_op = 1'b1;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_BEQ, OP_JMP: begin
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          OP_LW, OP_SW: state_next = ST_MEM;
          default:      state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timeout) begin
          state_next = ST_HALT;
        end
      end
      ST_WB: begin
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // Any state change restarts the wait count, so FETCH and MEM each begin at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      to_cnt      <= '0;
      bus_err     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if (state == ST_DECODE) op_q <= opcode;
      if (state_next != state)        to_cnt <= '0;
      else if (mem_wait && !mem_ready) to_cnt <= to_cnt + 1'b1;
      if (timeout) bus_err <= 1'b1;
      if (retire)  retired_cnt <= retired_cnt + 1'b1;
    end
  end

  seq_ctrl_decode u_decode (
    .state        (state),
    .op           (op_q),
    .alu_zero     (alu_zero),
    .mem_ready    (mem_ready),
    .control_pipe (control_pipe),
    .alu_opcode   (alu_opcode)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic        alu_zero;
  logic [8:0]  control_pipe;
  logic [1:0]  alu_opcode;
  logic [2:0]  state_o;
  logic        halted;
  logic        bus_err;
  logic        illegal_op;
  logic [15:0] retired_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] pipe;
    logic [1:0] alu;
    logic       ill;
  } exp_t;

  exp_t sb[$];

  multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .alu_zero     (alu_zero),
    .control_pipe (control_pipe),
    .alu_opcode   (alu_opcode),
    .state_o      (state_o),
    .halted       (halted),
    .bus_err      (bus_err),
    .illegal_op   (illegal_op),
    .retired_cnt  (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock: drive inputs, queue the expected outputs, check at negedge, step past posedge
  task automatic cyc(input logic mr, input logic az, input logic [3:0] op, input string tag,
                     input logic [2:0] est, input logic [8:0] epipe, input logic [1:0] ealu,
                     input logic eill);
    exp_t e;
    mem_ready = mr;
    alu_zero  = az;
    opcode    = op;
    sb.push_back('{st: est, pipe: epipe, alu: ealu, ill: eill});
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_state"}, 32'(state_o), 32'(e.st));
    chk({tag, "_pipe"}, 32'(control_pipe), 32'(e.pipe));
    chk({tag, "_alu"}, 32'(alu_opcode), 32'(e.alu));
    chk({tag, "_ill"}, 32'(illegal_op), 32'(e.ill));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input logic [3:0] op, input string tag);
    cyc(1'b1, 1'b0, op, {tag, "_fetch"}, 3'd0, 9'b110100000, 2'b00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = 4'h0;
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pipe", 32'(control_pipe), 32'h020);
    chk("rst_alu", 32'(alu_opcode), 32'd0);
    chk("rst_retired", 32'(retired_cnt), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD, memory always ready
    fetch_ok(4'h0, "add");
    cyc(1'b1, 1'b0, 4'h0, "add_dec",  3'd1, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, "add_exec", 3'd2, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, "add_wb",   3'd4, 9'b001000000, 2'b00, 1'b0);
    chk("add_retired", 32'(retired_cnt), 32'd1);

    // OR exercises the register ALU opcode pass-through
    fetch_ok(4'h3, "or");
    cyc(1'b0, 1'b0, 4'h3, "or_dec",  3'd1, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 4'h3, "or_exec", 3'd2, 9'b000000000, 2'b11, 1'b0);
    cyc(1'b0, 1'b0, 4'h3, "or_wb",   3'd4, 9'b001000000, 2'b00, 1'b0);
    chk("or_retired", 32'(retired_cnt), 32'd2);

    // LW with three wait states in MEM
    fetch_ok(4'h5, "lw");
    cyc(1'b0, 1'b0, 4'h5, "lw_dec",  3'd1, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 4'h5, "lw_exec", 3'd2, 9'b000001000, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 4'h5, "lw_mem_wait", 3'd3, 9'b000100000, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 4'h5, "lw_mem_rdy", 3'd3, 9'b000100000, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 4'h5, "lw_wb",      3'd4, 9'b001000100, 2'b00, 1'b0);
    chk("lw_retired", 32'(retired_cnt), 32'd3);

    // BEQ taken, then not taken
    fetch_ok(4'h7, "beq1");
    cyc(1'b0, 1'b0, 4'h7, "beq1_dec",  3'd1, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b0, 1'b1, 4'h7, "beq1_exec", 3'd2, 9'b100000010, 2'b01, 1'b0);
    chk("beq1_state", 32'(state_o), 32'd0);
    chk("beq1_retired", 32'(retired_cnt), 32'd4);
    fetch_ok(4'h7, "beq0");
    cyc(1'b0, 1'b0, 4'h7, "beq0_dec",  3'd1, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 4'h7, "beq0_exec", 3'd2, 9'b000000000, 2'b01, 1'b0);
    chk("beq0_state", 32'(state_o), 32'd0);
    chk("beq0_retired", 32'(retired_cnt), 32'd5);

    // JMP
    fetch_ok(4'h8, "jmp");
    cyc(1'b0, 1'b0, 4'h8, "jmp_dec",  3'd1, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 4'h8, "jmp_exec", 3'd2, 9'b100000001, 2'b00, 1'b0);
    chk("jmp_retired", 32'(retired_cnt), 32'd6);

    // SW, zero wait states
    fetch_ok(4'h6, "sw");
    cyc(1'b0, 1'b0, 4'h6, "sw_dec",  3'd1, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 4'h6, "sw_exec", 3'd2, 9'b000001000, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 4'h6, "sw_mem",  3'd3, 9'b000010000, 2'b00, 1'b0);
    chk("sw_state", 32'(state_o), 32'd0);
    chk("sw_retired", 32'(retired_cnt), 32'd7);

    // ADDI with mem_ready held high where it must be ignored
    fetch_ok(4'h4, "addi");
    cyc(1'b1, 1'b0, 4'h4, "addi_dec",  3'd1, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 4'h4, "addi_exec", 3'd2, 9'b000001000, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 4'h4, "addi_wb",   3'd4, 9'b001000000, 2'b00, 1'b0);
    chk("addi_retired", 32'(retired_cnt), 32'd8);

    // Illegal opcode: one-cycle pulse, counted as retired
    fetch_ok(4'hA, "ill");
    cyc(1'b0, 1'b0, 4'hA, "ill_dec", 3'd1, 9'b000000000, 2'b00, 1'b1);
    chk("ill_retired", 32'(retired_cnt), 32'd9);
    cyc(1'b0, 1'b0, 4'hA, "ill_after", 3'd0, 9'b000100000, 2'b00, 1'b0);

    // Reset asserted during a stalled SW memory phase
    fetch_ok(4'h6, "swr");
    cyc(1'b0, 1'b0, 4'h6, "swr_dec",  3'd1, 9'b000000000, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 4'h6, "swr_exec", 3'd2, 9'b000001000, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 4'h6, "swr_mem",  3'd3, 9'b000010000, 2'b00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("swr_mem_we", 32'(control_pipe[4]), 32'd0);
    chk("swr_state", 32'(state_o), 32'd0);
    chk("swr_retired", 32'(retired_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fetch timeout with MEM_TIMEOUT=4
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 4'h0, "to_wait", 3'd0, 9'b000100000, 2'b00, 1'b0);
    chk("to_pre_bus_err", 32'(bus_err), 32'd0);
    cyc(1'b0, 1'b0, 4'h0, "to_last", 3'd0, 9'b000100000, 2'b00, 1'b0);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_state", 32'(state_o), 32'd5);
    chk("to_retired", 32'(retired_cnt), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("to_rst_bus_err", 32'(bus_err), 32'd0);
    rst_n = 1'b1;

    // HLT: parks in HALT regardless of inputs
    fetch_ok(4'hF, "hlt");
    cyc(1'b0, 1'b0, 4'hF, "hlt_dec", 3'd1, 9'b000000000, 2'b00, 1'b0);
    for (int i = 0; i < 50; i++) begin
      mem_ready = 1'($urandom);
      alu_zero  = 1'($urandom);
      opcode    = 4'($urandom);
      @(negedge clk);
      chk("hlt_hold", {20'd0, halted, state_o, control_pipe}, {20'd0, 1'b1, 3'd5, 9'd0});
      @(posedge clk); #1;
    end
    chk("hlt_retired", 32'(retired_cnt), 32'd0);
    chk("hlt_bus_err", 32'(bus_err), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
